index_rom_scheduler: RTL and testbench
======================================

Name: index_rom_scheduler

Overview:
Owns the single-port background index ROM fed by the per-pixel index address logic. Shares the ROM between the VGA draw path (absolute priority, fixed latency) and the game-logic collision-query port (valid/ready). Sequences room (level) changes so that room_cur only switches during vertical blank, after in-flight reads drain. Sits between the index address generator, the index ROM and the Mario collision/physics logic.

Parameters:
ADDR_W, 9, index address width (per-room offset into ROM)
DATA_W, 8, ROM word width
ROM_LAT, 1, ROM read latency in Clk cycles (1..3)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
vblank_start  in  1  one-cycle pulse at start of vertical blank
draw_req  in  1  draw path needs ROM this cycle (is_index qualified by pixel enable)
draw_addr  in  ADDR_W  draw path index address
draw_valid  out  1  draw_data valid pulse
draw_data  out  DATA_W  ROM word for draw path
col_req_valid  in  1  collision query valid
col_req_addr  in  ADDR_W  collision query address
col_req_ready  out  1  query accepted this cycle
col_rsp_valid  out  1  collision response pulse, no backpressure
col_rsp_data  out  DATA_W  collision response word
room_req_valid  in  1  request room change
room_req  in  3  requested room number
room_cur  out  3  committed room, drives ROM upper address bits
room_busy  out  1  room change pending/in progress
rom_addr  out  ADDR_W  ROM address
rom_data  in  DATA_W  ROM read data, ROM_LAT cycles after rom_addr

Behaviour:
- Reset: room_cur=3'd1; room_busy, draw_valid, col_req_ready, col_rsp_valid=0; rom_addr, draw_data, col_rsp_data=0; FSM=IDLE; tag pipeline cleared; outstanding flag cleared.
- Arbitration per cycle: draw_req=1 -> rom_addr=draw_addr, tag DRAW. Else if col grant -> rom_addr=col_req_addr, tag COL. Else rom_addr=0, tag NONE.
- col_req_ready (combinational) = col_req_valid & !draw_req & !col_outstanding & FSM in {IDLE,PENDING}. Requester holds addr stable while valid & !ready.
- col_outstanding set on grant, cleared when col_rsp_valid fires; at most one collision read in flight.
- Tag shift register, depth ROM_LAT: at exit, DRAW -> draw_valid=1, draw_data=rom_data; COL -> col_rsp_valid=1, col_rsp_data=rom_data. Both outputs one-cycle pulses; data registers hold last value.
- Latency: request cycle N -> response at end of cycle N+ROM_LAT (registered outputs valid in cycle N+ROM_LAT).
- Room FSM:
  IDLE: room_req_valid & room_req!=room_cur -> latch pending_room, PENDING. Equal room -> ignored, stays IDLE.
  PENDING: new room_req_valid overwrites pending_room; vblank_start -> COMMIT.
  COMMIT (1 cycle): room_cur<=pending_room; no collision grants -> FLUSH.
  FLUSH: held ROM_LAT cycles (counter) to drain tags -> IDLE, or PENDING if a request arrived during COMMIT/FLUSH.
- room_busy=1 in PENDING, COMMIT, FLUSH.
- Room request arriving in the same cycle as vblank_start while IDLE: latched, commit waits for next vblank_start.
- draw_req during COMMIT/FLUSH still served (no stall); draw owner must not issue during vblank.
- Reset mid-operation: pending room and in-flight tags discarded; no response pulses afterwards.

Optional Feature:
INDEX_SCHED_STATS_EN: adds outputs col_wait_max[15:0] (longest cycles any collision query waited valid&!ready, saturating) and room_switch_cnt[7:0] (wrapping count of COMMITs), both cleared by Reset. Without it, those ports and counters are absent; arbitration unchanged.

Decomposition:
- Package index_sched_pkg: owner_t enum {OWN_NONE, OWN_DRAW, OWN_COL}; room_state_t enum {IDLE, PENDING, COMMIT, FLUSH}; ROOM_RESET=3'd1.
- Sub-module index_tag_pipe: ROM_LAT-deep owner-tag shift register with Reset.

Test Plan:
- Reset then idle -> room_cur=1, all pulses 0, rom_addr=0.
- draw_req=1, draw_addr=9'h05A, ROM model returns 8'h3C at LAT=1 -> draw_valid one cycle later, draw_data=8'h3C.
- draw_req and col_req_valid same cycle, col addr 9'h010 -> col_req_ready=0 until first draw_req=0 cycle; col_rsp_valid exactly ROM_LAT cycles after grant, data matches ROM[0x010]; second col request held off until response.
- room_req=2 mid-frame -> room_busy=1, room_cur stays 1 until vblank_start; COMMIT switches to 2; busy clears after ROM_LAT FLUSH cycles; col_req_ready=0 during COMMIT/FLUSH.
- room_req=2 then room_req=3 before vblank -> commits 3; room_req=1 while room_cur=1 -> no busy.
- Reset asserted during FLUSH with collision read in flight -> no col_rsp_valid after reset, room_cur=1.

Source files
------------

// File: rtl/index_sched_pkg.sv
// Shared types for the index ROM scheduler: ROM owner tags, room-change FSM
// states, the post-reset room and a saturating counter helper.
package index_sched_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DRAW,
    OWN_COL
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    COMMIT,
    FLUSH
  } room_state_t;

  localparam logic [2:0] ROOM_RESET = 3'd1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/index_tag_pipe.sv
// Owner-tag delay line that is LAT stages deep. Each tag comes out of the
// pipe in the same cycle as the ROM word for that read.
module index_tag_pipe
  import index_sched_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic   Clk,
  input  logic   Reset,
  input  owner_t tag_i,
  output owner_t tag_o
);

  owner_t stage_q [LAT];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LAT; i++) stage_q[i] <= OWN_NONE;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[LAT-1];

endmodule

// File: rtl/index_rom_scheduler.sv
// Shares the background index ROM between the draw path and collision queries,
// and switches rooms only in vertical blank. Define INDEX_SCHED_STATS_EN to add wait/switch stats.
//
// Collision handshake: a query transfers in a cycle where col_req_valid and
// col_req_ready are both high. col_req_ready depends combinationally on
// col_req_valid and draw_req, and the requester holds col_req_addr stable while
// the query is waiting. col_rsp_valid pulses ROM_LAT cycles after the transfer
// and has no backpressure.
module index_rom_scheduler
  import index_sched_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vblank_start,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_valid,
  output logic [DATA_W-1:0] draw_data,
  input  logic              col_req_valid,
  input  logic [ADDR_W-1:0] col_req_addr,
  output logic              col_req_ready,
  output logic              col_rsp_valid,
  output logic [DATA_W-1:0] col_rsp_data,
  input  logic              room_req_valid,
  input  logic [2:0]        room_req,
  output logic [2:0]        room_cur,
  output logic              room_busy,
  output logic [ADDR_W-1:0] rom_addr,
`ifdef INDEX_SCHED_STATS_EN
  output logic [15:0]       col_wait_max,
  output logic [7:0]        room_switch_cnt,
`endif
  output room_state_t       room_state_dbg,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [1:0] FLUSH_LOAD = 2'(ROM_LAT - 1);

  room_state_t       state_q, state_d;
  logic [2:0]        room_cur_q, room_cur_d;
  logic [2:0]        pending_q, pending_d;
  logic              again_q, again_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic              col_outstanding_q;
  logic [DATA_W-1:0] draw_data_q;
  logic [DATA_W-1:0] col_data_q;
  logic              col_grant;
  owner_t            tag_in;
  owner_t            tag_out;

  // Collision queries are blocked while the room is switching.
  assign col_grant = ~Reset & col_req_valid & ~draw_req & ~col_outstanding_q &
                     ((state_q == IDLE) | (state_q == PENDING));
  assign col_req_ready = col_grant;

  always_comb begin
    rom_addr = '0;
    tag_in   = OWN_NONE;
    if (!Reset) begin
      if (draw_req) begin
        rom_addr = draw_addr;
        tag_in   = OWN_DRAW;
      end else if (col_grant) begin
        rom_addr = col_req_addr;
        tag_in   = OWN_COL;
      end
    end
  end

  index_tag_pipe #(.LAT(ROM_LAT)) u_tag_pipe (
    .Clk   (Clk),
    .Reset (Reset),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  // During reset the last tag can still leave the pipe, so response pulses are gated.
  assign draw_valid    = ~Reset & (tag_out == OWN_DRAW);
  assign col_rsp_valid = ~Reset & (tag_out == OWN_COL);
  assign draw_data     = draw_valid ? rom_data : draw_data_q;
  assign col_rsp_data  = col_rsp_valid ? rom_data : col_data_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      draw_data_q       <= '0;
      col_data_q        <= '0;
      col_outstanding_q <= 1'b0;
    end else begin
      if (draw_valid) draw_data_q <= rom_data;
      if (col_rsp_valid) col_data_q <= rom_data;
      if (col_grant) col_outstanding_q <= 1'b1;
      else if (col_rsp_valid) col_outstanding_q <= 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    room_cur_d  = room_cur_q;
    pending_d   = pending_q;
    again_d     = again_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (room_req_valid && (room_req != room_cur_q)) begin
          pending_d = room_req;
          state_d   = PENDING;
        end
      end
      PENDING: begin
        if (room_req_valid) pending_d = room_req;
        if (vblank_start) state_d = COMMIT;
      end
      COMMIT: begin
        room_cur_d  = pending_q;
        flush_cnt_d = FLUSH_LOAD;
        state_d     = FLUSH;
        if (room_req_valid && (room_req != pending_q)) begin
          pending_d = room_req;
          again_d   = 1'b1;
        end
      end
      FLUSH: begin
        if (room_req_valid && (room_req != room_cur_q)) begin
          pending_d = room_req;
          again_d   = 1'b1;
        end
        if (flush_cnt_q == 2'd0) begin
          state_d = again_d ? PENDING : IDLE;
          again_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      room_cur_q  <= ROOM_RESET;
      pending_q   <= ROOM_RESET;
      again_q     <= 1'b0;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      room_cur_q  <= room_cur_d;
      pending_q   <= pending_d;
      again_q     <= again_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign room_cur       = room_cur_q;
  assign room_busy      = (state_q != IDLE);
  assign room_state_dbg = state_q;

`ifdef INDEX_SCHED_STATS_EN
  logic [15:0] wait_cur_q, wait_cur_d, wait_max_q;
  logic [7:0]  switch_cnt_q;

  assign wait_cur_d = (col_req_valid & ~col_grant) ? sat_inc16(wait_cur_q) : 16'd0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wait_cur_q   <= '0;
      wait_max_q   <= '0;
      switch_cnt_q <= '0;
    end else begin
      wait_cur_q <= wait_cur_d;
      if (wait_cur_d > wait_max_q) wait_max_q <= wait_cur_d;
      if (state_q == COMMIT) switch_cnt_q <= switch_cnt_q + 8'd1;
    end
  end

  assign col_wait_max    = wait_max_q;
  assign room_switch_cnt = switch_cnt_q;
`endif

endmodule

// File: tb/tb_index_rom_scheduler.sv
// Directed bench for index_rom_scheduler: a table of per-cycle vectors, a few
// hand-written reset sequences, and a queue of expected collision responses.
module tb_index_rom_scheduler;
  import index_sched_pkg::*;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 8;
  localparam int ROM_LAT = 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              vblank_start, draw_req, col_req_valid, room_req_valid;
  logic [ADDR_W-1:0] draw_addr, col_req_addr, rom_addr;
  logic [2:0]        room_req, room_cur;
  logic              draw_valid, col_req_ready, col_rsp_valid, room_busy;
  logic [DATA_W-1:0] draw_data, col_rsp_data, rom_data;
  room_state_t       room_state_dbg;
`ifdef INDEX_SCHED_STATS_EN
  logic [15:0]       col_wait_max;
  logic [7:0]        room_switch_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_room = 3'd1;
  logic [DATA_W-1:0] exp_q[$];

  // clock / reset block
  always #5 Clk = ~Clk;

  index_rom_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .Clk(Clk), .Reset(Reset), .vblank_start(vblank_start),
    .draw_req(draw_req), .draw_addr(draw_addr),
    .draw_valid(draw_valid), .draw_data(draw_data),
    .col_req_valid(col_req_valid), .col_req_addr(col_req_addr),
    .col_req_ready(col_req_ready), .col_rsp_valid(col_rsp_valid),
    .col_rsp_data(col_rsp_data), .room_req_valid(room_req_valid),
    .room_req(room_req), .room_cur(room_cur), .room_busy(room_busy),
    .rom_addr(rom_addr),
`ifdef INDEX_SCHED_STATS_EN
    .col_wait_max(col_wait_max), .room_switch_cnt(room_switch_cnt),
`endif
    .room_state_dbg(room_state_dbg), .rom_data(rom_data)
  );

  // ROM contents: address byte XOR (room << 5), with one hand-picked word.
  function automatic logic [7:0] rom_val(input logic [2:0] r, input logic [8:0] a);
    if (r == 3'd1 && a == 9'h05A) return 8'h3C;
    return a[7:0] ^ {r, 5'd0};
  endfunction

  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  always @(posedge Clk) begin
    rom_pipe[0] <= rom_val(room_cur, rom_addr);
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected collision responses from the bench ROM function
  always @(negedge Clk) begin
    if (col_rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL col_sb_unexpected: got pulse data %0h expected no pulse", col_rsp_data);
      end else begin
        check("col_sb_data", 32'(col_rsp_data), 32'(exp_q.pop_front()));
      end
    end
    if (Reset) exp_q.delete();
    else if (col_req_valid && col_req_ready) exp_q.push_back(rom_val(exp_room, col_req_addr));
  end

  typedef struct {
    logic       dreq;  logic [8:0] daddr;
    logic       cval;  logic [8:0] caddr;
    logic       rval;  logic [2:0] room;  logic vb;
    logic       e_dv;  logic [7:0] e_dd;
    logic       e_crdy; logic e_crv; logic [7:0] e_crd;
    logic       e_busy; logic [2:0] e_room; logic [8:0] e_addr;
  } vec_t;

  function automatic vec_t v(int dreq, int daddr, int cval, int caddr, int rval, int room,
                             int vb, int dv, int dd, int crdy, int crv, int crd,
                             int busy, int rc, int addr);
    vec_t r;
    r.dreq = 1'(dreq);   r.daddr = 9'(daddr);
    r.cval = 1'(cval);   r.caddr = 9'(caddr);
    r.rval = 1'(rval);   r.room = 3'(room);   r.vb = 1'(vb);
    r.e_dv = 1'(dv);     r.e_dd = 8'(dd);
    r.e_crdy = 1'(crdy); r.e_crv = 1'(crv);   r.e_crd = 8'(crd);
    r.e_busy = 1'(busy); r.e_room = 3'(rc);   r.e_addr = 9'(addr);
    return r;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    vblank_start = 1'b0; draw_req = 1'b0; draw_addr = '0;
    col_req_valid = 1'b0; col_req_addr = '0; room_req_valid = 1'b0; room_req = '0;
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply(input vec_t x);
    draw_req = x.dreq; draw_addr = x.daddr;
    col_req_valid = x.cval; col_req_addr = x.caddr;
    room_req_valid = x.rval; room_req = x.room; vblank_start = x.vb;
    exp_room = x.e_room;
  endtask

  vec_t vecs[26];

  initial begin
    //        dreq daddr  cv caddr rv rm vb | dv dd    crdy crv crd  busy room addr
    vecs[0]  = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h00, 0, 0, 'h00, 0, 1, 'h000);
    vecs[1]  = v(1, 'h05A, 0, 'h000, 0, 0, 0,  0, 'h00, 0, 0, 'h00, 0, 1, 'h05A);
    vecs[2]  = v(0, 'h000, 1, 'h010, 0, 0, 0,  1, 'h3C, 1, 0, 'h00, 0, 1, 'h010);
    vecs[3]  = v(1, 'h025, 1, 'h011, 0, 0, 0,  0, 'h3C, 0, 1, 'h30, 0, 1, 'h025);
    vecs[4]  = v(1, 'h021, 1, 'h011, 0, 0, 0,  1, 'h05, 0, 0, 'h30, 0, 1, 'h021);
    vecs[5]  = v(0, 'h000, 1, 'h011, 0, 0, 0,  1, 'h01, 1, 0, 'h30, 0, 1, 'h011);
    vecs[6]  = v(0, 'h000, 1, 'h012, 0, 0, 0,  0, 'h01, 0, 1, 'h31, 0, 1, 'h000);
    vecs[7]  = v(0, 'h000, 1, 'h012, 0, 0, 0,  0, 'h01, 1, 0, 'h31, 0, 1, 'h012);
    vecs[8]  = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h01, 0, 1, 'h32, 0, 1, 'h000);
    vecs[9]  = v(0, 'h000, 0, 'h000, 1, 2, 0,  0, 'h01, 0, 0, 'h32, 0, 1, 'h000);
    vecs[10] = v(0, 'h000, 1, 'h013, 0, 0, 0,  0, 'h01, 1, 0, 'h32, 1, 1, 'h013);
    vecs[11] = v(0, 'h000, 0, 'h000, 0, 0, 1,  0, 'h01, 0, 1, 'h33, 1, 1, 'h000);
    vecs[12] = v(0, 'h000, 1, 'h014, 0, 0, 0,  0, 'h01, 0, 0, 'h33, 1, 1, 'h000);
    vecs[13] = v(0, 'h000, 1, 'h014, 0, 0, 0,  0, 'h01, 0, 0, 'h33, 1, 2, 'h000);
    vecs[14] = v(0, 'h000, 1, 'h014, 0, 0, 0,  0, 'h01, 1, 0, 'h33, 0, 2, 'h014);
    vecs[15] = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h01, 0, 1, 'h54, 0, 2, 'h000);
    vecs[16] = v(0, 'h000, 0, 'h000, 1, 2, 0,  0, 'h01, 0, 0, 'h54, 0, 2, 'h000);
    vecs[17] = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h01, 0, 0, 'h54, 0, 2, 'h000);
    vecs[18] = v(0, 'h000, 0, 'h000, 1, 1, 1,  0, 'h01, 0, 0, 'h54, 0, 2, 'h000);
    vecs[19] = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h01, 0, 0, 'h54, 1, 2, 'h000);
    vecs[20] = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h01, 0, 0, 'h54, 1, 2, 'h000);
    vecs[21] = v(0, 'h000, 0, 'h000, 1, 3, 0,  0, 'h01, 0, 0, 'h54, 1, 2, 'h000);
    vecs[22] = v(0, 'h000, 0, 'h000, 0, 0, 1,  0, 'h01, 0, 0, 'h54, 1, 2, 'h000);
    vecs[23] = v(1, 'h030, 0, 'h000, 0, 0, 0,  0, 'h01, 0, 0, 'h54, 1, 2, 'h030);
    vecs[24] = v(0, 'h000, 1, 'h015, 0, 0, 0,  1, 'h70, 0, 0, 'h54, 1, 3, 'h000);
    vecs[25] = v(0, 'h000, 0, 'h000, 0, 0, 0,  0, 'h70, 0, 0, 'h54, 0, 3, 'h000);

    Reset = 1'b1;
    idle_inputs();
    repeat (3) next_cycle();
    @(negedge Clk);
    check("rst_draw_valid", 32'(draw_valid), 32'd0);
    check("rst_col_rsp_valid", 32'(col_rsp_valid), 32'd0);
    check("rst_room_cur", 32'(room_cur), 32'd1);
    next_cycle();
    Reset = 1'b0;

    for (int i = 0; i < 26; i++) begin
      apply(vecs[i]);
      @(negedge Clk);
      check($sformatf("v%0d_draw_valid", i), 32'(draw_valid), 32'(vecs[i].e_dv));
      check($sformatf("v%0d_draw_data", i), 32'(draw_data), 32'(vecs[i].e_dd));
      check($sformatf("v%0d_col_req_ready", i), 32'(col_req_ready), 32'(vecs[i].e_crdy));
      check($sformatf("v%0d_col_rsp_valid", i), 32'(col_rsp_valid), 32'(vecs[i].e_crv));
      check($sformatf("v%0d_col_rsp_data", i), 32'(col_rsp_data), 32'(vecs[i].e_crd));
      check($sformatf("v%0d_room_busy", i), 32'(room_busy), 32'(vecs[i].e_busy));
      check($sformatf("v%0d_room_cur", i), 32'(room_cur), 32'(vecs[i].e_room));
      check($sformatf("v%0d_rom_addr", i), 32'(rom_addr), 32'(vecs[i].e_addr));
      next_cycle();
    end

    // Reset during a room switch with a collision read in flight
    idle_inputs();
    exp_room = 3'd3;
    room_req_valid = 1'b1; room_req = 3'd2;
    next_cycle();
    idle_inputs();
    @(negedge Clk);
    check("seq_pending_busy", 32'(room_busy), 32'd1);
    next_cycle();
    vblank_start = 1'b1; col_req_valid = 1'b1; col_req_addr = 9'h040;
    @(negedge Clk);
    check("seq_vblank_grant", 32'(col_req_ready), 32'd1);
    next_cycle();
    idle_inputs();
    Reset = 1'b1;
    @(negedge Clk);
    check("seq_rst_no_rsp", 32'(col_rsp_valid), 32'd0);
    check("seq_rst_no_draw", 32'(draw_valid), 32'd0);
    next_cycle();
    Reset = 1'b0;
    exp_room = 3'd1;
    col_req_valid = 1'b1; col_req_addr = 9'h041;
    @(negedge Clk);
    check("seq_post_room_cur", 32'(room_cur), 32'd1);
    check("seq_post_busy", 32'(room_busy), 32'd0);
    check("seq_post_no_rsp", 32'(col_rsp_valid), 32'd0);
    check("seq_post_rsp_data", 32'(col_rsp_data), 32'd0);
    check("seq_post_ready", 32'(col_req_ready), 32'd1);
    next_cycle();
    idle_inputs();
    @(negedge Clk);
    check("seq_recover_rsp", 32'(col_rsp_valid), 32'd1);
    check("seq_recover_data", 32'(col_rsp_data), 32'h61);
    next_cycle();
    @(negedge Clk);
    check("seq_quiet_rsp", 32'(col_rsp_valid), 32'd0);
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
